ap_dispatch: RTL and testbench
==============================

# ap_dispatch

Parametrised accelerator-platform dispatcher between the PS-side instruction/DMA FIFOs and the engine FIFOs. Buffers instructions in an internal queue and issues one DMA burst command at a time through a valid/ready handshake. Tracks burst beats. Moves DMA input data to the engine-input (AEQ) FIFO and merges NCH engine-output (EAQ) FIFOs onto the DMA output FIFO. All queues are true circular buffers with occupancy counters.

## Interface
- OPW, 2: opcode width
- ADDR_W, 32: address width
- DATA_W, 64: data width
- DEPTH_LOG2, 3: log2 depth of each internal queue (instr, in-data, out-data)
- NCH, 2: number of EAQ channels, 1..8
- RD_BURST, 8: beats per read command (1..255)
- WR_BURST, 16: beats per write command (1..255)

Ports. Reset is rst_n, synchronous, active-low; clock is clk. All input FIFOs are first-word-fall-through: dout is valid while !empty, and rd_en pops.
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- isa_empty  in  1  instruction FIFO empty
- isa_dout  in  OPW+ADDR_W  {opcode, address}
- isa_rd_en  out  1  instruction pop
- din_empty  in  1  DMA input FIFO empty
- din_dout  in  DATA_W  DMA input data
- din_rd_en  out  1  DMA input pop
- aeq_full  in  1  AEQ FIFO full
- aeq_din  out  DATA_W  AEQ write data
- aeq_wr_en  out  1  AEQ write
- eaq_empty  in  NCH  per-channel empty
- eaq_dout  in  NCH*DATA_W  channel c at bits [c*DATA_W +: DATA_W]
- eaq_rd_en  out  NCH  one-hot pop
- dout_full  in  1  DMA output FIFO full
- dout_din  out  DATA_W  DMA output data
- dout_wr_en  out  1  DMA output write
- cmd_valid  out  1  command valid
- cmd_ready  in  1  DMA engine accepts command
- cmd_op  out  OPW  command opcode
- cmd_addr  out  ADDR_W  command address
- cmd_burst  out  8  beats in command
- busy  out  1  FSM not IDLE or any queue non-empty
- ecn  out  1  congestion: aeq_full or dout_full
- err  out  1  sticky: illegal opcode seen

## Operation
- **Instruction queue.** isa_rd_en = !isa_empty && instr_cnt < 2^DEPTH_LOG2. Each pop pushes {opcode, address}. Opcode 00 is dropped silently. Opcode 11 is dropped and sets err, which is cleared only by reset. 01 is read; 10 is write.
- **Command FSM, IDLE.** If the queue is non-empty: pop the head, load cmd_op/cmd_addr, set cmd_burst = RD_BURST (01) or WR_BURST (10), load beat_cnt = cmd_burst, go to ISSUE.
- **Command FSM, ISSUE.** cmd_valid=1, and the outputs stay stable until cmd_ready. On cmd_valid && cmd_ready, go to RUN.
- **Command FSM, RUN.** beat_cnt decrements on each aeq_wr_en (read op) or each dout_wr_en (write op). When a beat fires with beat_cnt==1, go to IDLE.
- **Input path.** din_rd_en = !din_empty && in_cnt not full. aeq_wr_en = in_cnt!=0 && !aeq_full. aeq_din = queue head.
- **Output path.** Each cycle, grant at most one channel c with !eaq_empty[c] while out_cnt is not full. The grant pops the channel and pushes its data. dout_wr_en = out_cnt!=0 && !dout_full.
- **Data path vs FSM.** The data paths flow independently of the FSM. The FSM only counts beats.
- **Queue pointers and counters.** Pointers are DEPTH_LOG2 bits and wrap modulo depth. Counters are DEPTH_LOG2+1 bits. A simultaneous push and pop leaves the count unchanged. The full check uses the current count, so no push occurs at full even when a pop happens in the same cycle.
- **Reset.** Clears all pointers and counters, the FSM (to IDLE), beat_cnt, err, and the arbiter pointer. Queue storage is not cleared. Reset mid-burst abandons the command with no further beats counted.

## Timing
- Output reset values: cmd_valid=0, cmd_op=0, cmd_addr=0, cmd_burst=0, busy=0, err=0, aeq_din=0, dout_din=0.
- rd_en and wr_en outputs are combinational from counters and flags. Data outputs come directly from queue registers.
- Latency from isa pop to cmd_valid is 2 cycles when idle: queue write, then the IDLE load.
- din pop to aeq_wr_en: 1 cycle. EAQ pop to dout_wr_en: 1 cycle.
- A single command sustains 1 beat per cycle when FIFOs allow.
- Back-to-back commands: 1 IDLE cycle between the last beat and the next cmd_valid.

## Configuration
- AP_RR_ARB_EN defined: round-robin EAQ arbitration. The search starts at the channel after the last granted one, skips empty channels, and the pointer advances only on a grant.
- Undefined: fixed priority, lowest-index non-empty channel wins, no pointer state.

## Test plan
- **Single read.** isa_dout={01,0x1000_0000}, then 8 din words 0..7, aeq never full. Expect cmd_valid with cmd_burst=8 and addr 0x1000_0000, 8 aeq writes in order, FSM back to IDLE, busy=0.
- **Write with EAQ merge.** Write command, NCH=2, both channels holding 8 words each, AP_RR_ARB_EN defined. Expect cmd_burst=16, dout alternates ch0/ch1, and exactly 16 beats are counted.
- **Backpressure and wrap.** Hold aeq_full=1 for 20 cycles while din supplies 12 words. Expect din_rd_en to drop after 8, ecn=1, then all 12 words in order once the full is released, with the pointers wrapped.
- **Opcode filter.** Issue opcodes 00, 11, 01. Expect exactly one command (read), err=1 after the 11, and err staying 1.
- **cmd_ready stall.** Hold cmd_ready=0 for 5 cycles. Expect cmd_valid, cmd_addr and cmd_burst stable throughout, and handshake on the first ready cycle.
- **Reset mid-burst.** Assert rst_n=0 after 3 of 8 beats. Expect cmd_valid=0, all counts=0 and err=0 on the next edge, and normal operation for the following command.

Source files
------------

// File: rtl/ap_dispatch.sv
// ap_dispatch -- accelerator-platform dispatcher.
//
// Takes {opcode, address} words from the instruction FIFO into an internal
// queue and issues one DMA burst command at a time through a valid/ready
// handshake. The command FSM counts burst beats. Two data paths run on
// their own, whatever the FSM is doing:
//   DMA input FIFO   -> in-queue  -> AEQ FIFO
//   NCH EAQ channels -> out-queue -> DMA output FIFO
//
// Opcodes: 00 dropped silently, 01 read (RD_BURST beats), 10 write
// (WR_BURST beats), 11 dropped and sets the sticky err flag.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   isa_empty/isa_dout/isa_rd_en    instruction FIFO (first-word-fall-through)
//   din_empty/din_dout/din_rd_en    DMA input FIFO (first-word-fall-through)
//   aeq_full/aeq_din/aeq_wr_en      engine-input FIFO write side
//   eaq_empty/eaq_dout/eaq_rd_en    NCH engine-output FIFOs, one-hot pop
//   dout_full/dout_din/dout_wr_en   DMA output FIFO write side
//   cmd_valid/cmd_ready/cmd_op/cmd_addr/cmd_burst   DMA command handshake
//   busy  FSM not idle or any internal queue non-empty
//   ecn   congestion (aeq_full or dout_full)
//   err   sticky, illegal opcode seen
//
// Build option: define AP_RR_ARB_EN for round-robin EAQ arbitration;
// without it the lowest-index non-empty channel wins.

// Circular buffer with occupancy counter and a first-word-fall-through
// head. Pushes at full and pops at empty are ignored. The head reads as
// zero while the queue is empty, so outputs fed from it are 0 out of reset.
module ap_dispatch_q #(
  parameter int W          = 64,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [W-1:0]          din_i,
  output logic [W-1:0]          dout_o,
  output logic [DEPTH_LOG2:0]   cnt_o,
  output logic                  full_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = DEPTH[DEPTH_LOG2:0];

  logic [W-1:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0]   wp_q, rp_q;
  logic [DEPTH_LOG2:0]     cnt_q;
  logic                    do_push, do_pop;

  // Full is judged on the current count: a pop in the same cycle does not
  // make room for a push.
  assign full_o  = (cnt_q == FULL_CNT);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && (cnt_q != '0);

  // Storage is not reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop)  rp_q <= rp_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign dout_o = (cnt_q != '0) ? mem_q[rp_q] : '0;
  assign cnt_o  = cnt_q;
endmodule

module ap_dispatch #(
  parameter int OPW        = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int DEPTH_LOG2 = 3,
  parameter int NCH        = 2,
  parameter int RD_BURST   = 8,
  parameter int WR_BURST   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    isa_empty,
  input  logic [OPW+ADDR_W-1:0]   isa_dout,
  output logic                    isa_rd_en,
  input  logic                    din_empty,
  input  logic [DATA_W-1:0]       din_dout,
  output logic                    din_rd_en,
  input  logic                    aeq_full,
  output logic [DATA_W-1:0]       aeq_din,
  output logic                    aeq_wr_en,
  input  logic [NCH-1:0]          eaq_empty,
  input  logic [NCH*DATA_W-1:0]   eaq_dout,
  output logic [NCH-1:0]          eaq_rd_en,
  input  logic                    dout_full,
  output logic [DATA_W-1:0]       dout_din,
  output logic                    dout_wr_en,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic [OPW-1:0]          cmd_op,
  output logic [ADDR_W-1:0]       cmd_addr,
  output logic [7:0]              cmd_burst,
  output logic                    busy,
  output logic                    ecn,
  output logic                    err
);
  localparam int IW = OPW + ADDR_W;
  localparam int AW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [OPW-1:0] OP_RD  = OPW'(1);
  localparam logic [OPW-1:0] OP_WR  = OPW'(2);
  localparam logic [OPW-1:0] OP_ILL = OPW'(3);
  localparam logic [7:0] RD_B = 8'(RD_BURST);
  localparam logic [7:0] WR_B = 8'(WR_BURST);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RUN} state_t;

  // ---------------- instruction queue ----------------
  logic [IW-1:0]       iq_head;
  logic [DEPTH_LOG2:0] iq_cnt, in_cnt, out_cnt;
  logic                iq_full, in_full, out_full;
  logic                iq_push, iq_pop;
  logic [OPW-1:0]      isa_op;

  assign isa_op    = isa_dout[IW-1 -: OPW];
  assign isa_rd_en = !isa_empty && !iq_full;
  // Only read and write instructions are queued; the others are consumed here.
  assign iq_push   = isa_rd_en && (isa_op == OP_RD || isa_op == OP_WR);

  ap_dispatch_q #(.W(IW), .DEPTH_LOG2(DEPTH_LOG2)) u_iq (
    .clk(clk), .rst_n(rst_n), .push_i(iq_push), .pop_i(iq_pop),
    .din_i(isa_dout), .dout_o(iq_head), .cnt_o(iq_cnt), .full_o(iq_full)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)                             err <= 1'b0;
    else if (isa_rd_en && isa_op == OP_ILL) err <= 1'b1;
  end

  // ---------------- input path ----------------
  assign din_rd_en = !din_empty && !in_full;
  assign aeq_wr_en = (in_cnt != '0) && !aeq_full;

  ap_dispatch_q #(.W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_inq (
    .clk(clk), .rst_n(rst_n), .push_i(din_rd_en), .pop_i(aeq_wr_en),
    .din_i(din_dout), .dout_o(aeq_din), .cnt_o(in_cnt), .full_o(in_full)
  );

  // ---------------- output path / EAQ arbiter ----------------
  logic [DATA_W-1:0] eaq_data [NCH];
  logic [AW-1:0]     gnt_idx;
  logic              gnt_v;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_eaq
    assign eaq_data[gi] = eaq_dout[gi*DATA_W +: DATA_W];
  end

`ifdef AP_RR_ARB_EN
  // Last granted channel; the search starts just after it.
  logic [AW-1:0] arb_last_q;

  always_ff @(posedge clk) begin
    if (!rst_n)     arb_last_q <= '0;
    else if (gnt_v) arb_last_q <= gnt_idx;
  end

  always_comb begin
    int idx;
    idx     = 0;
    gnt_v   = 1'b0;
    gnt_idx = '0;
    if (!out_full) begin
      for (int k = 1; k <= NCH; k++) begin
        idx = (int'(arb_last_q) + k) % NCH;
        if (!gnt_v && !eaq_empty[idx]) begin
          gnt_v   = 1'b1;
          gnt_idx = AW'(idx);
        end
      end
    end
  end
`else
  always_comb begin
    gnt_v   = 1'b0;
    gnt_idx = '0;
    if (!out_full) begin
      for (int k = 0; k < NCH; k++) begin
        if (!gnt_v && !eaq_empty[k]) begin
          gnt_v   = 1'b1;
          gnt_idx = AW'(k);
        end
      end
    end
  end
`endif

  always_comb begin
    eaq_rd_en = '0;
    if (gnt_v) eaq_rd_en[gnt_idx] = 1'b1;
  end

  assign dout_wr_en = (out_cnt != '0) && !dout_full;

  ap_dispatch_q #(.W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_outq (
    .clk(clk), .rst_n(rst_n), .push_i(gnt_v), .pop_i(dout_wr_en),
    .din_i(eaq_data[gnt_idx]), .dout_o(dout_din), .cnt_o(out_cnt), .full_o(out_full)
  );

  // ---------------- command FSM ----------------
  state_t            state_q, state_d;
  logic [OPW-1:0]    cmd_op_q, cmd_op_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [7:0]        cmd_burst_q, cmd_burst_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;
  logic              beat;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cmd_op_q    <= '0;
      cmd_addr_q  <= '0;
      cmd_burst_q <= '0;
      beat_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_op_q    <= cmd_op_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_burst_q <= cmd_burst_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_op_d    = cmd_op_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_burst_d = cmd_burst_q;
    beat_cnt_d  = beat_cnt_q;
    iq_pop      = 1'b0;
    // A beat is whichever data-path write matches the command direction.
    beat        = (cmd_op_q == OP_RD) ? aeq_wr_en : dout_wr_en;
    case (state_q)
      S_IDLE: begin
        if (iq_cnt != '0) begin
          iq_pop      = 1'b1;
          cmd_op_d    = iq_head[IW-1 -: OPW];
          cmd_addr_d  = iq_head[ADDR_W-1:0];
          // The queue only holds reads and writes.
          cmd_burst_d = (iq_head[IW-1 -: OPW] == OP_RD) ? RD_B : WR_B;
          beat_cnt_d  = cmd_burst_d;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cmd_ready) state_d = S_RUN;
      end
      S_RUN: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q - 1'b1;
          if (beat_cnt_q == 8'd1) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_valid = (state_q == S_ISSUE);
  assign cmd_op    = cmd_op_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_burst = cmd_burst_q;
  assign busy      = (state_q != S_IDLE) || (iq_cnt != '0) || (in_cnt != '0) || (out_cnt != '0);
  assign ecn       = aeq_full || dout_full;
endmodule

// File: tb/tb_ap_dispatch.sv
// tb_ap_dispatch -- directed test of ap_dispatch with FIFO models for the
// instruction, DMA input and EAQ FIFOs, and logs of AEQ / DMA output writes
// and accepted commands.
module tb_ap_dispatch;
  localparam int OPW = 2, ADDR_W = 32, DATA_W = 64, NCH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n, isa_empty, isa_rd_en, din_empty, din_rd_en;
  logic [OPW+ADDR_W-1:0] isa_dout;
  logic [DATA_W-1:0]     din_dout, aeq_din, dout_din;
  logic                  aeq_full, aeq_wr_en, dout_full, dout_wr_en;
  logic [NCH-1:0]        eaq_empty, eaq_rd_en;
  logic [NCH*DATA_W-1:0] eaq_dout;
  logic                  cmd_valid, cmd_ready, busy, ecn, err;
  logic [OPW-1:0]        cmd_op;
  logic [ADDR_W-1:0]     cmd_addr;
  logic [7:0]            cmd_burst;

  ap_dispatch #(.OPW(OPW), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_LOG2(3),
                .NCH(NCH), .RD_BURST(8), .WR_BURST(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .isa_empty(isa_empty), .isa_dout(isa_dout), .isa_rd_en(isa_rd_en),
    .din_empty(din_empty), .din_dout(din_dout), .din_rd_en(din_rd_en),
    .aeq_full(aeq_full), .aeq_din(aeq_din), .aeq_wr_en(aeq_wr_en),
    .eaq_empty(eaq_empty), .eaq_dout(eaq_dout), .eaq_rd_en(eaq_rd_en),
    .dout_full(dout_full), .dout_din(dout_din), .dout_wr_en(dout_wr_en),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_burst(cmd_burst),
    .busy(busy), .ecn(ecn), .err(err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // FIFO models and logs
  logic [OPW+ADDR_W-1:0] isa_q[$];
  logic [63:0] din_q[$], eaq0_q[$], eaq1_q[$], aeq_log[$], dout_log[$];
  int cyc = 0, cmd_cnt = 0, isa_pop_cyc = 0, valid_rise_cyc = 0, onehot_bad = 0;
  logic [OPW-1:0]    last_op = '0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [7:0]        last_burst = '0;
  logic              prev_valid = 1'b0;

  function automatic void drive_models();
    isa_empty = (isa_q.size() == 0);
    isa_dout  = isa_empty ? '0 : isa_q[0];
    din_empty = (din_q.size() == 0);
    din_dout  = din_empty ? '0 : din_q[0];
    eaq_empty = {eaq1_q.size() == 0, eaq0_q.size() == 0};
    eaq_dout  = {(eaq1_q.size() == 0) ? 64'h0 : eaq1_q[0],
                 (eaq0_q.size() == 0) ? 64'h0 : eaq0_q[0]};
  endfunction

  // Sample DUT at the falling edge, apply pops/writes just after the rising edge.
  initial begin
    logic s_rst, s_isa, s_din, s_aw, s_dw;
    logic [NCH-1:0] s_eaq;
    logic [63:0] s_ad, s_dd;
    drive_models();
    forever begin
      @(negedge clk);
      cyc++;
      s_rst = rst_n; s_isa = isa_rd_en; s_din = din_rd_en; s_eaq = eaq_rd_en;
      s_aw = aeq_wr_en; s_ad = aeq_din; s_dw = dout_wr_en; s_dd = dout_din;
      if (rst_n) begin
        if (cmd_valid && !prev_valid) valid_rise_cyc = cyc;
        if (cmd_valid && cmd_ready) begin
          cmd_cnt++;
          last_op = cmd_op; last_addr = cmd_addr; last_burst = cmd_burst;
        end
        if (isa_rd_en) isa_pop_cyc = cyc;
        if ($countones(eaq_rd_en) > 1) onehot_bad++;
      end
      prev_valid = cmd_valid;
      @(posedge clk);
      #1;
      if (s_rst) begin
        if (s_isa && isa_q.size() > 0)     void'(isa_q.pop_front());
        if (s_din && din_q.size() > 0)     void'(din_q.pop_front());
        if (s_eaq[0] && eaq0_q.size() > 0) void'(eaq0_q.pop_front());
        if (s_eaq[1] && eaq1_q.size() > 0) void'(eaq1_q.pop_front());
        if (s_aw) aeq_log.push_back(s_ad);
        if (s_dw) dout_log.push_back(s_dd);
      end
      drive_models();
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_cmds(input int target, input string tag);
    int k = 0;
    while (cmd_cnt < target && k < 100) begin cycles(1); k++; end
    check_eq(tag, 64'(cmd_cnt), 64'(target));
  endtask

  task automatic wait_aeq(input int n, input string tag);
    int k = 0;
    while (aeq_log.size() < n && k < 200) begin cycles(1); k++; end
    check_eq(tag, 64'(aeq_log.size()), 64'(n));
  endtask

  task automatic wait_dout(input int n, input string tag);
    int k = 0;
    while (dout_log.size() < n && k < 200) begin cycles(1); k++; end
    check_eq(tag, 64'(dout_log.size()), 64'(n));
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 100) begin cycles(1); k++; end
    check_eq(tag, 64'(busy), 64'(0));
  endtask

  task automatic do_reset();
    isa_q.delete(); din_q.delete(); eaq0_q.delete(); eaq1_q.delete();
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [63:0] exp_w [16];
    rst_n = 1'b0; cmd_ready = 1'b0; aeq_full = 1'b0; dout_full = 1'b0;
    cycles(3);
    // ---- reset values ----
    check_eq("rst_cmd_valid", 64'(cmd_valid), 0);
    check_eq("rst_cmd_op", 64'(cmd_op), 0);
    check_eq("rst_cmd_addr", 64'(cmd_addr), 0);
    check_eq("rst_cmd_burst", 64'(cmd_burst), 0);
    check_eq("rst_busy", 64'(busy), 0);
    check_eq("rst_err", 64'(err), 0);
    check_eq("rst_aeq_din", aeq_din, 0);
    check_eq("rst_dout_din", dout_din, 0);
    rst_n = 1'b1;
    cycles(1);

    // ---- single read ----
    cmd_ready = 1'b1;
    base = cmd_cnt;
    isa_q.push_back({2'b01, 32'h1000_0000});
    wait_cmds(base + 1, "rd_handshake");
    check_eq("rd_op", 64'(last_op), 1);
    check_eq("rd_addr", 64'(last_addr), 64'h1000_0000);
    check_eq("rd_burst", 64'(last_burst), 8);
    check_eq("rd_latency", 64'(valid_rise_cyc - isa_pop_cyc), 2);
    aeq_log.delete();
    for (int i = 0; i < 8; i++) din_q.push_back(64'(i));
    wait_aeq(8, "rd_aeq_count");
    for (int i = 0; i < 8; i++) check_eq($sformatf("rd_aeq[%0d]", i), aeq_log[i], 64'(i));
    wait_idle("rd_idle");

    // ---- write with EAQ merge ----
    do_reset();
    base = cmd_cnt;
    isa_q.push_back({2'b10, 32'h2000_0040});
    wait_cmds(base + 1, "wr_handshake");
    check_eq("wr_op", 64'(last_op), 2);
    check_eq("wr_addr", 64'(last_addr), 64'h2000_0040);
    check_eq("wr_burst", 64'(last_burst), 16);
    dout_log.delete();
    for (int i = 0; i < 8; i++) begin
      eaq0_q.push_back(64'hA0 + 64'(i));
      eaq1_q.push_back(64'hB0 + 64'(i));
`ifdef AP_RR_ARB_EN
      // pointer resets to 0, so channel 1 is searched first
      exp_w[2*i]   = 64'hB0 + 64'(i);
      exp_w[2*i+1] = 64'hA0 + 64'(i);
`else
      exp_w[i]     = 64'hA0 + 64'(i);
      exp_w[i+8]   = 64'hB0 + 64'(i);
`endif
    end
    wait_dout(16, "wr_dout_count");
    for (int i = 0; i < 16; i++) check_eq($sformatf("wr_dout[%0d]", i), dout_log[i], exp_w[i]);
    check_eq("wr_onehot", 64'(onehot_bad), 0);
    wait_idle("wr_idle");

    // ---- backpressure and wrap ----
    aeq_log.delete();
    aeq_full = 1'b1;
    for (int i = 0; i < 12; i++) din_q.push_back(64'hC0 + 64'(i));
    cycles(20);
    check_eq("bp_din_rd_en", 64'(din_rd_en), 0);
    check_eq("bp_din_left", 64'(din_q.size()), 4);
    check_eq("bp_ecn", 64'(ecn), 1);
    check_eq("bp_aeq_wr_en", 64'(aeq_wr_en), 0);
    check_eq("bp_busy", 64'(busy), 1);
    aeq_full = 1'b0;
    wait_aeq(12, "bp_aeq_count");
    for (int i = 0; i < 12; i++) check_eq($sformatf("bp_aeq[%0d]", i), aeq_log[i], 64'hC0 + 64'(i));
    check_eq("bp_ecn_clear", 64'(ecn), 0);
    wait_idle("bp_idle");

    // ---- opcode filter ----
    check_eq("filt_err_before", 64'(err), 0);
    base = cmd_cnt;
    isa_q.push_back({2'b00, 32'h0000_0A00});
    isa_q.push_back({2'b11, 32'h0000_0B00});
    isa_q.push_back({2'b01, 32'h0000_0C00});
    wait_cmds(base + 1, "filt_handshake");
    check_eq("filt_op", 64'(last_op), 1);
    check_eq("filt_addr", 64'(last_addr), 64'h0C00);
    check_eq("filt_err", 64'(err), 1);
    aeq_log.delete();
    for (int i = 0; i < 8; i++) din_q.push_back(64'hD0 + 64'(i));
    wait_aeq(8, "filt_aeq_count");
    wait_idle("filt_idle");
    check_eq("filt_cmd_count", 64'(cmd_cnt), 64'(base + 1));
    check_eq("filt_err_sticky", 64'(err), 1);

    // ---- cmd_ready stall ----
    cmd_ready = 1'b0;
    base = cmd_cnt;
    isa_q.push_back({2'b10, 32'h3000_0000});
    for (int k = 0; k < 20 && !cmd_valid; k++) cycles(1);
    check_eq("stall_valid_seen", 64'(cmd_valid), 1);
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("stall_hold[%0d]", i), {23'h0, cmd_valid, cmd_addr, cmd_burst},
               {23'h0, 1'b1, 32'h3000_0000, 8'd16});
      cycles(1);
    end
    check_eq("stall_no_hs", 64'(cmd_cnt), 64'(base));
    cmd_ready = 1'b1;
    cycles(1);
    check_eq("stall_hs", 64'(cmd_cnt), 64'(base + 1));
    check_eq("stall_valid_drop", 64'(cmd_valid), 0);
    dout_log.delete();
    for (int i = 0; i < 16; i++) eaq0_q.push_back(64'hE0 + 64'(i));
    wait_dout(16, "stall_dout_count");
    check_eq("stall_dout_first", dout_log[0], 64'hE0);
    check_eq("stall_dout_last", dout_log[15], 64'hEF);
    wait_idle("stall_idle");

    // ---- reset mid-burst ----
    base = cmd_cnt;
    isa_q.push_back({2'b01, 32'h4000_0000});
    wait_cmds(base + 1, "mid_handshake");
    aeq_log.delete();
    for (int i = 0; i < 3; i++) din_q.push_back(64'h40 + 64'(i));
    wait_aeq(3, "mid_aeq_count");
    rst_n = 1'b0;
    cycles(1);
    check_eq("mid_cmd_valid", 64'(cmd_valid), 0);
    check_eq("mid_busy", 64'(busy), 0);
    check_eq("mid_err", 64'(err), 0);
    check_eq("mid_cmd_burst", 64'(cmd_burst), 0);
    check_eq("mid_aeq_wr_en", 64'(aeq_wr_en), 0);
    rst_n = 1'b1;
    cycles(1);
    base = cmd_cnt;
    isa_q.push_back({2'b01, 32'h5000_0000});
    wait_cmds(base + 1, "post_handshake");
    check_eq("post_addr", 64'(last_addr), 64'h5000_0000);
    check_eq("post_burst", 64'(last_burst), 8);
    aeq_log.delete();
    for (int i = 0; i < 8; i++) din_q.push_back(64'hF0 + 64'(i));
    wait_aeq(8, "post_aeq_count");
    for (int i = 0; i < 8; i++) check_eq($sformatf("post_aeq[%0d]", i), aeq_log[i], 64'hF0 + 64'(i));
    wait_idle("post_idle");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
